// File: rtl/des_key_schedule.sv
// DES key schedule: rotates PC-1 C/D halves per round and emits PC-2 subkeys one per handshake.
// Optional DES_KS_REVERSE_EN adds K16..K1 (decrypt) ordering; without it every sequence is K1..K16.
module des_key_schedule (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        decrypt,
  input  logic [27:0] cbits,
  input  logic [27:0] dbits,
  input  logic        sk_ready,
  output logic        sk_valid,
  output logic [47:0] subkey,
  output logic [3:0]  sk_round,
  output logic        busy,
  output logic        done
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // One-based PC-2 selection, indexed by output bit j (subkey[j] = CD[PC2[j]-1]).
  localparam logic [5:0] PC2 [48] = '{
    6'd14, 6'd17, 6'd11, 6'd24, 6'd1,  6'd5,
    6'd3,  6'd28, 6'd15, 6'd6,  6'd21, 6'd10,
    6'd23, 6'd19, 6'd12, 6'd4,  6'd26, 6'd8,
    6'd16, 6'd7,  6'd27, 6'd20, 6'd13, 6'd2,
    6'd41, 6'd52, 6'd31, 6'd37, 6'd47, 6'd55,
    6'd30, 6'd40, 6'd51, 6'd45, 6'd33, 6'd48,
    6'd44, 6'd49, 6'd39, 6'd56, 6'd34, 6'd53,
    6'd46, 6'd42, 6'd50, 6'd36, 6'd29, 6'd32
  };

  state_e      state_q, state_d;
  logic [27:0] c_q, c_d;
  logic [27:0] d_q, d_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        done_q, done_d;
  logic        last_round;

  // Bit 0 is DES bit 1, so a DES left rotate is a right shift of the vector.
  function automatic logic [27:0] rotl1(input logic [27:0] x);
    return {x[0], x[27:1]};
  endfunction

  function automatic logic [27:0] rotl2(input logic [27:0] x);
    return {x[1:0], x[27:2]};
  endfunction

  // Rounds 1, 2, 9 and 16 shift by one place, all others by two.
  function automatic logic single_shift(input logic [4:0] r);
    return (r == 5'd1) || (r == 5'd2) || (r == 5'd9) || (r == 5'd16);
  endfunction

  function automatic logic [47:0] pc2(input logic [27:0] c, input logic [27:0] d);
    logic [55:0] cd;
    logic [47:0] k;
    cd = {d, c};
    k  = '0;
    for (int j = 0; j < 48; j++) begin
      k[j] = cd[PC2[j] - 6'd1];
    end
    return k;
  endfunction

`ifdef DES_KS_REVERSE_EN
  logic dir_q, dir_d;

  function automatic logic [27:0] rotr1(input logic [27:0] x);
    return {x[26:0], x[27]};
  endfunction

  function automatic logic [27:0] rotr2(input logic [27:0] x);
    return {x[25:0], x[27:26]};
  endfunction

  assign last_round = dir_q ? (cnt_q == 4'd0) : (cnt_q == 4'd15);
`else
  logic unused_decrypt;
  assign unused_decrypt = decrypt;
  assign last_round     = (cnt_q == 4'd15);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      c_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
`ifdef DES_KS_REVERSE_EN
      dir_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
`ifdef DES_KS_REVERSE_EN
      dir_q   <= dir_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
`ifdef DES_KS_REVERSE_EN
    dir_d   = dir_q;
`endif
    case (state_q)
      IDLE: begin
        if (load) begin
          state_d = RUN;
`ifdef DES_KS_REVERSE_EN
          dir_d = decrypt;
          // K16 uses a total shift of 28, i.e. the unrotated halves.
          if (decrypt) begin
            c_d   = cbits;
            d_d   = dbits;
            cnt_d = 4'd15;
          end else begin
            c_d   = rotl1(cbits);
            d_d   = rotl1(dbits);
            cnt_d = 4'd0;
          end
`else
          c_d   = rotl1(cbits);
          d_d   = rotl1(dbits);
          cnt_d = 4'd0;
`endif
        end
      end
      RUN: begin
        if (sk_ready) begin
          if (last_round) begin
            state_d = IDLE;
            done_d  = 1'b1;
            cnt_d   = 4'd0;
          end else begin
`ifdef DES_KS_REVERSE_EN
            if (dir_q) begin
              // Undo the shift that produced the current round.
              if (single_shift({1'b0, cnt_q} + 5'd1)) begin
                c_d = rotr1(c_q);
                d_d = rotr1(d_q);
              end else begin
                c_d = rotr2(c_q);
                d_d = rotr2(d_q);
              end
              cnt_d = cnt_q - 4'd1;
            end else begin
              if (single_shift({1'b0, cnt_q} + 5'd2)) begin
                c_d = rotl1(c_q);
                d_d = rotl1(d_q);
              end else begin
                c_d = rotl2(c_q);
                d_d = rotl2(d_q);
              end
              cnt_d = cnt_q + 4'd1;
            end
`else
            if (single_shift({1'b0, cnt_q} + 5'd2)) begin
              c_d = rotl1(c_q);
              d_d = rotl1(d_q);
            end else begin
              c_d = rotl2(c_q);
              d_d = rotl2(d_q);
            end
            cnt_d = cnt_q + 4'd1;
`endif
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign sk_valid = (state_q == RUN);
  assign busy     = (state_q == RUN);
  assign done     = done_q;
  assign sk_round = cnt_q;
  assign subkey   = sk_valid ? pc2(c_q, d_q) : 48'd0;

endmodule

// File: tb/tb_des_key_schedule.sv
// Randomized and directed bench for des_key_schedule against a standard-notation DES key-schedule model.
module tb_des_key_schedule;

  logic        clk;
  logic        rst_n;
  logic        load;
  logic        decrypt;
  logic [27:0] cbits;
  logic [27:0] dbits;
  logic        sk_ready;
  logic        sk_valid;
  logic [47:0] subkey;
  logic [3:0]  sk_round;
  logic        busy;
  logic        done;

  des_key_schedule dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .decrypt  (decrypt),
    .cbits    (cbits),
    .dbits    (dbits),
    .sk_ready (sk_ready),
    .sk_valid (sk_valid),
    .subkey   (subkey),
    .sk_round (sk_round),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam int PC2_TB [48] = '{
    14, 17, 11, 24, 1, 5, 3, 28, 15, 6, 21, 10,
    23, 19, 12, 4, 26, 8, 16, 7, 27, 20, 13, 2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  int n_chk  = 0;
  int n_pass = 0;

  function automatic logic [27:0] rev28(input logic [27:0] x);
    logic [27:0] y;
    for (int i = 0; i < 28; i++) y[i] = x[27-i];
    return y;
  endfunction

  function automatic logic [47:0] rev48(input logic [47:0] x);
    logic [47:0] y;
    for (int i = 0; i < 48; i++) y[i] = x[47-i];
    return y;
  endfunction

  // Textbook DES: halves held bit-1-at-MSB, rotated left by the cumulative shift, PC-2 read MSB first.
  function automatic logic [47:0] model_key(input logic [27:0] c, input logic [27:0] d, input int n);
    logic [27:0] mc, md;
    logic [55:0] cd;
    logic [47:0] k;
    int sh;
    mc = rev28(c);
    md = rev28(d);
    sh = 0;
    for (int r = 1; r <= n; r++) sh += (r == 1 || r == 2 || r == 9 || r == 16) ? 1 : 2;
    for (int i = 0; i < sh; i++) begin
      mc = {mc[26:0], mc[27]};
      md = {md[26:0], md[27]};
    end
    cd = {mc, md};
    for (int j = 1; j <= 48; j++) k[48-j] = cd[56-PC2_TB[j-1]];
    return k;
  endfunction

  task automatic chk(input string nm, input logic [47:0] act, input logic [47:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, required %h", nm, act, exp);
  endtask

  // Sequence-level model: which key is on offer, and whether done is pulsing.
  logic        m_run;
  logic        m_dir;
  logic [3:0]  m_round;
  logic        m_done;
  logic [47:0] m_keys [16];
  logic        checking = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run   <= 1'b0;
      m_dir   <= 1'b0;
      m_round <= 4'd0;
      m_done  <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (!m_run) begin
        if (load) begin
          m_run <= 1'b1;
`ifdef DES_KS_REVERSE_EN
          m_dir   <= decrypt;
          m_round <= decrypt ? 4'd15 : 4'd0;
`else
          m_dir   <= 1'b0;
          m_round <= 4'd0;
`endif
          for (int r = 0; r < 16; r++) m_keys[r] <= model_key(cbits, dbits, r + 1);
        end
      end else if (sk_ready) begin
        if ((m_dir && m_round == 4'd0) || (!m_dir && m_round == 4'd15)) begin
          m_run   <= 1'b0;
          m_round <= 4'd0;
          m_done  <= 1'b1;
        end else begin
          m_round <= m_dir ? m_round - 4'd1 : m_round + 4'd1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      chk("sk_valid", {47'd0, sk_valid}, {47'd0, m_run});
      chk("busy", {47'd0, busy}, {47'd0, m_run});
      chk("done", {47'd0, done}, {47'd0, m_done});
      chk("sk_round", {44'd0, sk_round}, {44'd0, m_round});
      if (m_run) chk("subkey", rev48(subkey), m_keys[m_round]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic start(input logic [27:0] c, input logic [27:0] d, input logic dec);
    load    = 1'b1;
    cbits   = c;
    dbits   = d;
    decrypt = dec;
    tick();
    load = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      tick();
      if (done) seen = 1'b1;
    end
    chk("wait_done", {47'd0, seen}, 48'd1);
  endtask

  logic [27:0] kc, kd, rc, rd, tmp28;
  logic [47:0] k1_lit, k16_lit, prev_sub;
  logic [3:0]  prev_rnd;
  logic        hold_pending, seen;
  int          accepted;

  initial begin
    rst_n = 1'b0; load = 1'b0; decrypt = 1'b0; sk_ready = 1'b0;
    cbits = '0; dbits = '0;
    tmp28 = 28'b1111000011001100101010101111; kc = rev28(tmp28);
    tmp28 = 28'b0101010101100110011110001111; kd = rev28(tmp28);
    k1_lit  = 48'h1B02EFFC7072;
    k16_lit = 48'hCB3D8B0E17F5;

    chk("model_k1", model_key(kc, kd, 1), k1_lit);
    chk("model_k16", model_key(kc, kd, 16), k16_lit);

    repeat (2) tick();
    chk("rst_valid", {47'd0, sk_valid}, 48'd0);
    chk("rst_busy", {47'd0, busy}, 48'd0);
    chk("rst_done", {47'd0, done}, 48'd0);
    chk("rst_round", {44'd0, sk_round}, 48'd0);
    chk("rst_subkey", subkey, 48'd0);
    rst_n = 1'b1;
    checking = 1'b1;
    tick();

    // Forward known answer, full throughput.
    sk_ready = 1'b1;
    start(kc, kd, 1'b0);
    chk("fwd_first_key", rev48(subkey), k1_lit);
    chk("fwd_first_round", {44'd0, sk_round}, 48'd0);
    repeat (15) tick();
    chk("fwd_last_key", rev48(subkey), k16_lit);
    chk("fwd_last_round", {44'd0, sk_round}, 48'd15);
    tick();
    chk("fwd_done", {47'd0, done}, 48'd1);
    chk("fwd_busy_low", {47'd0, busy}, 48'd0);
    tick();

    // Decrypt request: reverse order when supported, forward otherwise.
    start(kc, kd, 1'b1);
`ifdef DES_KS_REVERSE_EN
    chk("rev_first_key", rev48(subkey), k16_lit);
    chk("rev_first_round", {44'd0, sk_round}, 48'd15);
    repeat (15) tick();
    chk("rev_last_key", rev48(subkey), k1_lit);
    chk("rev_last_round", {44'd0, sk_round}, 48'd0);
`else
    chk("nomacro_first_key", rev48(subkey), k1_lit);
    chk("nomacro_first_round", {44'd0, sk_round}, 48'd0);
`endif
    wait_done(40);
    tick();

    // Backpressure with sk_ready pattern 0,0,1.
    sk_ready = 1'b0;
    start(kc, kd, 1'b0);
    hold_pending = 1'b0;
    accepted = 0;
    seen = 1'b0;
    for (int k = 0; k < 80 && !seen; k++) begin
      if (hold_pending && sk_valid) begin
        chk("bp_hold_key", subkey, prev_sub);
        chk("bp_hold_round", {44'd0, sk_round}, {44'd0, prev_rnd});
      end
      sk_ready = (k % 3 == 2);
      if (sk_ready && sk_valid) accepted++;
      prev_sub = subkey;
      prev_rnd = sk_round;
      hold_pending = !sk_ready;
      tick();
      if (done) seen = 1'b1;
    end
    chk("bp_done_seen", {47'd0, seen}, 48'd1);
    chk("bp_accepted", 48'(accepted), 48'd16);
    sk_ready = 1'b1;
    tick();

    // Load while running is ignored; load in the done cycle is accepted.
    start(kc, kd, 1'b0);
    repeat (5) tick();
    load = 1'b1; cbits = 28'($urandom); dbits = 28'($urandom); decrypt = 1'b1;
    tick();
    load = 1'b0;
    wait_done(40);
    rc = 28'($urandom); rd = 28'($urandom);
    start(rc, rd, 1'b0);
    chk("done_cycle_load_valid", {47'd0, sk_valid}, 48'd1);
    chk("done_cycle_load_key", rev48(subkey), model_key(rc, rd, 1));

    // Asynchronous reset mid-sequence, then restart from K1.
    repeat (6) tick();
    #1 rst_n = 1'b0;
    #1;
    chk("arst_valid", {47'd0, sk_valid}, 48'd0);
    chk("arst_busy", {47'd0, busy}, 48'd0);
    chk("arst_round", {44'd0, sk_round}, 48'd0);
    chk("arst_subkey", subkey, 48'd0);
    tick();
    rst_n = 1'b1;
    tick();
    start(kc, kd, 1'b0);
    chk("restart_key", rev48(subkey), k1_lit);
    wait_done(40);
    tick();

    // Randomized sequences: random keys, order, ready and ignored loads.
    for (int s = 0; s < 20; s++) begin
      sk_ready = 1'($urandom);
      start(28'($urandom), 28'($urandom), 1'($urandom));
      seen = 1'b0;
      for (int k = 0; k < 200 && !seen; k++) begin
        sk_ready = 1'($urandom);
        load     = ($urandom_range(0, 3) == 0);
        cbits    = 28'($urandom);
        dbits    = 28'($urandom);
        decrypt  = 1'($urandom);
        tick();
        if (done) seen = 1'b1;
      end
      load = 1'b0;
      chk("rand_done_seen", {47'd0, seen}, 48'd1);
      if (s % 2 == 0) tick();
    end

    tick();
    checking = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks %0d passed of %0d", n_pass, n_chk);
    $fatal(1);
  end

endmodule

// File: doc/des_key_schedule.md
# des_key_schedule

Sequential DES key-schedule generator, directly downstream of the PC-1 permutation stage. Takes the 28-bit C and D halves PC-1 produces, rotates them round by round, and applies PC-2. Emits the sixteen 48-bit round subkeys one per handshake to the round-function datapath. Supports forward (encrypt, K1→K16) and reverse (decrypt, K16→K1) order.

## Interface
- No parameters. Widths are fixed by DES.
- clk, in, 1: sole clock; all state updates on the rising edge.
- rst_n, in, 1: asynchronous, active-low reset.
- load, in, 1: start request; sampled only in IDLE.
- decrypt, in, 1: order select, sampled with load: 0 = K1..K16, 1 = K16..K1.
- cbits, in, 28: C0 from PC-1. cbits[i] is standard DES C bit i+1.
- dbits, in, 28: D0 from PC-1, same indexing.
- sk_ready, in, 1: consumer accepts the current subkey.
- sk_valid, out, 1: subkey and sk_round are valid.
- subkey, out, 48: current round key. subkey[j] is standard PC-2 output bit j+1.
- sk_round, out, 4: round index of the current subkey, 0..15 = K1..K16.
- busy, out, 1: high while not IDLE.
- done, out, 1: one-cycle pulse after the 16th subkey is accepted.

## Operation
- **States:** IDLE and RUN. Internal registers: C, D (28 each), cnt (4), dir (1).
- **Rotation, index form:** a standard left rotate by 1 maps new[i] = old[(i+1) mod 28], which is a right shift of the vector. Right rotate is the inverse.
- **Shift schedule s(r):** s(r) = 1 for rounds r = 1, 2, 9, 16; s(r) = 2 for all other rounds.
- **CD vector:** CD[k] = C[k] for k < 28, and CD[k] = D[k−28] for k ≥ 28.
- **PC-2:** subkey[j] = CD[PC2_j − 1], using the FIPS 46-3 PC-2 table. PC-2 is combinational from the C/D registers.
- **IDLE, load=1:**
  - dir ← decrypt.
  - Forward: C ← rotl1(cbits), D ← rotl1(dbits), sk_round starts at 0.
  - Reverse: C ← cbits, D ← dbits (no rotation), sk_round starts at 15.
  - Go to RUN.
- **RUN, sk_valid = 1 throughout:**
  - Without a handshake, all state holds and subkey/sk_round are stable.
  - On handshake (sk_valid & sk_ready), if not the last round:
    - Forward: rotate left by s(sk_round+2), increment sk_round.
    - Reverse: rotate right by s(sk_round+1), decrement sk_round.
  - Handshake on the last round (sk_round 15 forward, 0 reverse): go to IDLE, pulse done, clear sk_round to 0.
- **load in RUN:** ignored. Input changes in RUN do not affect the sequence.
- **Reset, including mid-sequence:** IDLE; C, D, cnt, dir cleared. Outputs: sk_valid 0, busy 0, done 0, sk_round 0, subkey 0. No partial sequence resumes.

## Timing
- **First subkey:** sk_valid rises in the cycle after the load edge (1-cycle latency).
- **Throughput:** with sk_ready held high, 16 subkeys on 16 consecutive cycles.
- **End of sequence:** done and busy=0 appear in the cycle after the final handshake. A load in that cycle is accepted, giving back-to-back keys with one idle cycle.
- **Combinational paths:** subkey and sk_round are combinational only from registers. sk_ready has no combinational path to any output.

## Configuration
- **DES_KS_REVERSE_EN defined:** reverse (decrypt) order supported as described above.
- **DES_KS_REVERSE_EN undefined:**
  - The decrypt port remains but is ignored.
  - The dir register and right-rotate logic are removed.
  - Every sequence is forward, K1..K16.

## Test plan
- **Forward sequence, known-answer vector:**
  - Stimulus: C0 = 1111000011001100101010101111, D0 = 0101010101100110011110001111 (standard bit 1 first), decrypt=0, sk_ready=1.
  - Required: the first subkey, read from [0], is 000110110000001011101111111111000111000001110010 (0x1B02EFFC7072).
  - Required: the 16th subkey is 0xCB3D8B0E17F5 in the same reading.
  - Required: subkeys on consecutive cycles; done one cycle after the 16th.
- **Reverse sequence:**
  - Stimulus: same key, decrypt=1.
  - Required: first output has sk_round=15 with subkey 0xCB3D8B0E17F5; last output has sk_round=0 with subkey 0x1B02EFFC7072.
- **Backpressure:** sk_ready toggled 0,0,1 pattern; subkey and sk_round must hold while sk_ready=0. Same 16 values in the same order as the forward case.
- **Load during RUN:** load=1 with different C/D at round 5; sequence unaffected. Load in the done cycle is accepted; sk_valid is high the next cycle.
- **Reset mid-sequence:** rst_n=0 at round 7; all outputs 0 immediately, asynchronously. After release, a new load restarts at K1.
- **Macro undefined:** decrypt=1 still yields K1 first (0x1B02EFFC7072).
